// File: rtl/sort4_ctrl_pkg.sv
// Shared constants for the 4-entry sorter: state encodings, sizes and the
// bubble-sort step schedule.
package sort4_ctrl_pkg;

    localparam int N_ENTRIES = 4;
    localparam int DATA_W    = 4;
    localparam int IDX_W     = 2;
    localparam int STEP_W    = 3;
    localparam int CNT_W     = 3;

    localparam logic [IDX_W-1:0]  LAST_IDX  = 2'd3;
    localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SORT   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    // Six compare steps: pass0 j=0,1,2; pass1 j=0,1; pass2 j=0.
    function automatic logic [IDX_W-1:0] step_to_j(input logic [STEP_W-1:0] step);
        logic [IDX_W-1:0] j;
        case (step)
            3'd1, 3'd4: j = 2'd1;
            3'd2:       j = 2'd2;
            default:    j = 2'd0;
        endcase
        return j;
    endfunction

endpackage

// File: rtl/sort4_ctrl_cmp.sv
// Unsigned magnitude comparator shared by every compare step of the sorter.
module comparator4
    import sort4_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              eq,
    output logic              lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// Loads four 4-bit elements, bubble-sorts them in place over six fixed
// compare cycles, then streams them out with valid/ready handshaking.
module sort4_ctrl
    import sort4_ctrl_pkg::*;
#(
    parameter bit ASCENDING = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  swap_cnt
);

    state_t state, next_state;

    logic [DATA_W-1:0] mem [N_ENTRIES];
    logic [IDX_W-1:0]  wr_idx, rd_idx, j, j_next;
    logic [STEP_W-1:0] step;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              gt, eq, lt;
    logic              accept, transfer, do_swap;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_SORT);
    assign accept   = in_valid && in_ready;
    assign transfer = (state == ST_UNLOAD) && out_valid && out_ready;

    assign j      = step_to_j(step);
    assign j_next = j + 2'd1;
    assign cmp_a  = mem[j];
    assign cmp_b  = mem[j_next];

    comparator4 u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // Ties never swap, which keeps the sort stable.
    assign do_swap = busy && !eq && (ASCENDING ? gt : lt);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD:   if (accept && wr_idx == LAST_IDX) next_state = ST_SORT;
            ST_SORT:   if (step == LAST_STEP)            next_state = ST_UNLOAD;
            ST_UNLOAD: if (transfer && rd_idx == LAST_IDX) next_state = ST_LOAD;
            default:   next_state = ST_LOAD;
        endcase
    end

    // Storage has no reset; a fresh load overwrites every entry anyway.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                mem[wr_idx] <= in_data;
            end else if (do_swap) begin
                mem[j]      <= cmp_b;
                mem[j_next] <= cmp_a;
            end
        end
    end

    // The output register is primed on the first UNLOAD cycle, so the first
    // element shows up seven edges after the last load accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            step      <= '0;
            swap_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        wr_idx <= wr_idx + 2'd1;
                        if (wr_idx == '0) swap_cnt <= '0;
                    end
                end
                ST_SORT: begin
                    step <= (step == LAST_STEP) ? '0 : step + 3'd1;
                    if (do_swap) swap_cnt <= swap_cnt + 3'd1;
                end
                ST_UNLOAD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mem[rd_idx];
                    end else if (out_ready) begin
                        rd_idx <= rd_idx + 2'd1;
                        if (rd_idx == LAST_IDX) out_valid <= 1'b0;
                        else                    out_data  <= mem[rd_idx + 2'd1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench: an ascending and a descending sorter share all inputs, so
// each load exercises both orders with hand-computed expectations.
module tb_sort4_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, busy;
    logic [3:0] out_data;
    logic [2:0] swap_cnt;
    logic       d_in_ready, d_out_valid, d_busy;
    logic [3:0] d_out_data;
    logic [2:0] d_swap_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sort4_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .swap_cnt(swap_cnt)
    );

    sort4_ctrl #(.ASCENDING(1'b0)) dut_desc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_ready(out_ready), .busy(d_busy), .swap_cnt(d_swap_cnt)
    );

    // Element k of a packed 16-bit vector lives in bits [4k+3:4k].
    task automatic load4(input logic [15:0] vals);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i*4 +: 4];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit junk, output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        if (junk) in_valid = 1'b1;
        while (lat < 30) begin
            if (junk) in_data = 4'($urandom);
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic unload4(input bit junk, output logic [15:0] outs,
                           output logic [15:0] outs_d, output int valid_cnt);
        valid_cnt = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 4'($urandom);
            end
            outs[k*4 +: 4]   = out_data;
            outs_d[k*4 +: 4] = d_out_data;
            if (out_valid && d_out_valid) valid_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy, out_valid, out_data, swap_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0, 3'd0}) begin
            failures++;
            $display("[TB] FAIL reset_state got rdy=%b busy=%b ov=%b od=%0d sc=%0d",
                     in_ready, busy, out_valid, out_data, swap_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_sort(input string name, input logic [15:0] vals,
                             input logic [15:0] exp_a, input logic [2:0] exp_sc,
                             input logic [15:0] exp_d, input logic [2:0] exp_dsc,
                             input bit junk);
        int lat, bc, vc;
        logic [15:0] outs, outs_d;
        load4(vals);
        wait_valid(junk, lat, bc);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("[TB] FAIL %s latency got %0d expected 7", name, lat);
        end
        checks++;
        if (bc !== 6) begin
            failures++;
            $display("[TB] FAIL %s busy_cycles got %0d expected 6", name, bc);
        end
        unload4(junk, outs, outs_d, vc);
        checks++;
        if (outs !== exp_a || vc !== 4) begin
            failures++;
            $display("[TB] FAIL %s asc_out got %h (valid %0d) expected %h", name, outs, vc, exp_a);
        end
        checks++;
        if (swap_cnt !== exp_sc) begin
            failures++;
            $display("[TB] FAIL %s asc_swaps got %0d expected %0d", name, swap_cnt, exp_sc);
        end
        checks++;
        if (outs_d !== exp_d || d_swap_cnt !== exp_dsc) begin
            failures++;
            $display("[TB] FAIL %s desc got out=%h sc=%0d expected out=%h sc=%0d",
                     name, outs_d, d_swap_cnt, exp_d, exp_dsc);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s back_to_load got rdy=%b ov=%b expected rdy=1 ov=0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure;
        int lat, bc, vc;
        logic [15:0] outs, outs_d;
        load4(16'h1739);
        wait_valid(1'b0, lat, bc);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'd1) begin
                failures++;
                $display("[TB] FAIL backpressure_hold cycle %0d got ov=%b od=%0d expected ov=1 od=1",
                         c, out_valid, out_data);
            end
        end
        unload4(1'b0, outs, outs_d, vc);
        checks++;
        if (outs !== 16'h9731 || vc !== 4) begin
            failures++;
            $display("[TB] FAIL backpressure_order got %h (valid %0d) expected 9731", outs, vc);
        end
    endtask

    task automatic test_reset_mid_sort;
        load4(16'h1739);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, busy, swap_cnt, out_valid} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL mid_sort_reset got rdy=%b busy=%b sc=%0d ov=%b expected rdy=1 busy=0 sc=0 ov=0",
                     in_ready, busy, swap_cnt, out_valid);
        end
        test_sort("reload_2143", 16'h3412, 16'h4321, 3'd2, 16'h1234, 3'd4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sort("basic_9371",    16'h1739, 16'h9731, 3'd5, 16'h1379, 3'd1, 1'b0);
        test_sort("reverse_15_0",  16'h05AF, 16'hFA50, 3'd6, 16'h05AF, 3'd0, 1'b0);
        test_sort("forward_0_15",  16'hFA50, 16'hFA50, 3'd0, 16'h05AF, 3'd6, 1'b0);
        test_sort("ties_5555",     16'h5555, 16'h5555, 3'd0, 16'h5555, 3'd0, 1'b0);
        test_sort("sorted_1234",   16'h4321, 16'h4321, 3'd0, 16'h1234, 3'd6, 1'b0);
        test_backpressure();
        test_reset_mid_sort();
        test_sort("junk_in_valid", 16'h1739, 16'h9731, 3'd5, 16'h1379, 3'd1, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter ASCENDING, default 1: 1 = ascending output order, 0 = descending; fixed at elaboration.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_data holds a value to load.
REQ-005 in_data  input  4  unsigned element to load.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 out_valid  output  1  out_data holds a sorted element.
REQ-008 out_data  output  4  sorted element, unsigned.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 busy  output  1  high while sorting.
REQ-011 swap_cnt  output  3  number of swaps made by the last sort, range 0..6.

Function
REQ-012 The module SHALL hold 4 entries of 4 bits, mem[0..3], and a 3-state FSM: LOAD, SORT, UNLOAD.
REQ-013 In LOAD, in_ready=1; an accept (in_valid && in_ready) writes in_data to mem[wr_idx] and increments wr_idx 0..3.
REQ-014 The first accept of a LOAD phase SHALL clear swap_cnt to 0; swap_cnt SHALL otherwise hold outside SORT.
REQ-015 The 4th accept SHALL move the FSM to SORT on the next edge; wr_idx wraps to 0.
REQ-016 SORT SHALL use exactly one 4-bit magnitude comparator, shared across all compare steps, with A=mem[j] and B=mem[j+1].
REQ-017 SORT SHALL run a fixed bubble schedule, one compare per cycle: pass0 j=0,1,2; pass1 j=0,1; pass2 j=0. Always 6 cycles.
REQ-018 Swap condition: ASCENDING=1 -> A>B; ASCENDING=0 -> A<B. On a swap, mem[j] and mem[j+1] exchange at that edge and swap_cnt increments by 1.
REQ-019 Equal elements SHALL never swap (stable sort, zero swaps on ties).
REQ-020 busy=1 exactly during the 6 SORT cycles; in_ready=0 and out_valid=0 in SORT.
REQ-021 After the 6th compare the FSM SHALL enter UNLOAD; with the last load accept at edge t, out_valid first rises after edge t+7.
REQ-022 In UNLOAD, out_valid=1 and out_data=mem[rd_idx]; a transfer (out_valid && out_ready) increments rd_idx 0..3.
REQ-023 While out_ready=0, out_data and out_valid SHALL hold unchanged.
REQ-024 The 4th transfer SHALL return the FSM to LOAD on the next edge; rd_idx wraps to 0. No overlap of unload and the next load.
REQ-025 in_valid outside LOAD and out_ready outside UNLOAD SHALL be ignored.

Reset
REQ-026 rst=1 at a rising edge SHALL force state LOAD, wr_idx=0, rd_idx=0, j/pass=0, swap_cnt=0, busy=0, out_valid=0, out_data=0, in_ready=1 after that edge.
REQ-027 Reset SHALL take priority over every other event, including mid-SORT and mid-UNLOAD; partial data is discarded.
REQ-028 mem contents need not be cleared by reset.

Structure
REQ-029 State encodings (LOAD, SORT, UNLOAD), the entry count 4 and the data width 4 SHALL live in a shared constants package/include for the lab set.
REQ-030 The comparator SHALL be one sub-module instance, comparator4, with outputs gt/eq/lt; sort4_ctrl holds the FSM, storage and counters.

Verification
REQ-031 ASCENDING=1, load 9,3,7,1 -> after 6 busy cycles out 1,3,7,9; swap_cnt=5.
REQ-032 Load 15,10,5,0 -> out 0,5,10,15, swap_cnt=6; with ASCENDING=0, load 0,5,10,15 -> out 15,10,5,0, swap_cnt=6.
REQ-033 Load 5,5,5,5 -> out 5,5,5,5, swap_cnt=0; load 1,2,3,4 -> out unchanged, swap_cnt=0.
REQ-034 Back-pressure: out_ready=0 for 3 cycles after the first element appears -> out_data stays at 1 and out_valid stays 1; order is intact after release.
REQ-035 rst pulsed on SORT cycle 3 -> next cycle in_ready=1, busy=0, swap_cnt=0; a fresh load of 2,1,4,3 -> out 1,2,3,4, swap_cnt=2.
REQ-036 in_valid held high through SORT/UNLOAD with junk data -> no mem change, and the output sequence is unaffected.
